// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the 3x3 convolution block.
//   kernel_e      : frame-selectable kernel encoding (5-7 fall back to identity)
//   kernel_t      : 3x3 signed 4-bit coefficients, arithmetic right shift, abs flag
//   kernel_lookup : kernel_e -> kernel_t coefficient table
//   Channel widths, accumulator width and pipeline latency constants.
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int R_W          = 5;
    localparam int G_W          = 6;
    localparam int B_W          = 5;
    localparam int PIX_W        = R_W + G_W + B_W;
    localparam int ACC_W        = 16;
    localparam int COEF_W       = 4;
    localparam int CONV_LATENCY = 4;

    typedef enum logic [2:0] {
        IDENTITY = 3'd0,
        GAUSSIAN = 3'd1,
        SHARPEN  = 3'd2,
        SOBEL_X  = 3'd3,
        SOBEL_Y  = 3'd4
    } kernel_e;

    // coef[row][col]: row 0 = top, col 0 = leftmost (oldest) column.
    // Each coefficient is a two's-complement COEF_W-bit value.
    typedef struct packed {
        logic [2:0][2:0][COEF_W-1:0] coef;
        logic [2:0]                  shift;
        logic                        abs_en;
    } kernel_t;

    function automatic kernel_t make_kernel(
        input int   c00, input int c01, input int c02,
        input int   c10, input int c11, input int c12,
        input int   c20, input int c21, input int c22,
        input int   shift,
        input logic abs_en
    );
        kernel_t k;
        k.coef[0][0] = COEF_W'(c00);
        k.coef[0][1] = COEF_W'(c01);
        k.coef[0][2] = COEF_W'(c02);
        k.coef[1][0] = COEF_W'(c10);
        k.coef[1][1] = COEF_W'(c11);
        k.coef[1][2] = COEF_W'(c12);
        k.coef[2][0] = COEF_W'(c20);
        k.coef[2][1] = COEF_W'(c21);
        k.coef[2][2] = COEF_W'(c22);
        k.shift      = 3'(shift);
        k.abs_en     = abs_en;
        return k;
    endfunction

    function automatic kernel_t kernel_lookup(input kernel_e sel);
        kernel_t k;
        case (sel)
            GAUSSIAN: k = make_kernel( 1,  2,  1,   2, 4,  2,   1,  2,  1,  4, 1'b0);
            SHARPEN:  k = make_kernel( 0, -1,  0,  -1, 5, -1,   0, -1,  0,  0, 1'b0);
            SOBEL_X:  k = make_kernel(-1,  0,  1,  -2, 0,  2,  -1,  0,  1,  0, 1'b1);
            SOBEL_Y:  k = make_kernel(-1, -2, -1,   0, 0,  0,   1,  2,  1,  0, 1'b1);
            // IDENTITY and the unused encodings 5-7
            default:  k = make_kernel( 0,  0,  0,   0, 1,  0,   0,  0,  0,  0, 1'b0);
        endcase
        return k;
    endfunction

endpackage

// File: rtl/conv_channel.sv
// -----------------------------------------------------------------------------
// conv_channel
// One colour channel of the 3x3 convolution: pipeline stages 2-4.
//   stage 2: nine signed products (unsigned pixel x signed coefficient)
//   stage 3: sum into a signed ACC_W accumulator
//   stage 4: arithmetic shift, optional abs, clamp to [0, 2^CH_W-1]
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_win          : 3x3 unsigned channel window [row][col], stage-1 aligned
//   i_kernel       : kernel captured with this window
//   i_zero         : force the result to 0 (border pixel)
//   o_ch           : clamped channel result, 3 cycles after i_win
// -----------------------------------------------------------------------------
module conv_channel
    import conv_pkg::*;
#(
    parameter int CH_W = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [2:0][2:0][CH_W-1:0]  i_win,
    input  kernel_t                    i_kernel,
    input  logic                       i_zero,
    output logic [CH_W-1:0]            o_ch
);

    localparam logic signed [ACC_W-1:0] CH_MAX = ACC_W'((1 << CH_W) - 1);

    // ---------------- stage 2: products ----------------
    logic [8:0][ACC_W-1:0] w_prod;

    for (genvar gi = 0; gi < 9; gi++) begin : g_prod
        localparam int ROW = gi / 3;
        localparam int COL = gi % 3;
        logic signed [ACC_W-1:0] w_pix;
        logic signed [ACC_W-1:0] w_coef;

        assign w_pix  = ACC_W'(i_win[ROW][COL]);  // zero-extend: channels are unsigned
        assign w_coef = {{(ACC_W-COEF_W){i_kernel.coef[ROW][COL][COEF_W-1]}},
                         i_kernel.coef[ROW][COL]};
        assign w_prod[gi] = w_pix * w_coef;
    end

    logic [8:0][ACC_W-1:0] r_prod;
    logic [2:0]            r_shift_s2;
    logic                  r_abs_s2;
    logic                  r_zero_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prod     <= '0;
            r_shift_s2 <= '0;
            r_abs_s2   <= 1'b0;
            r_zero_s2  <= 1'b0;
        end else begin
            r_prod     <= w_prod;
            r_shift_s2 <= i_kernel.shift;
            r_abs_s2   <= i_kernel.abs_en;
            r_zero_s2  <= i_zero;
        end
    end

    // ---------------- stage 3: accumulate ----------------
    // Written as a chain; synthesis balances it into a tree.
    logic signed [ACC_W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) begin
            w_sum = w_sum + $signed(r_prod[i]);
        end
    end

    logic signed [ACC_W-1:0] r_sum;
    logic [2:0]              r_shift_s3;
    logic                    r_abs_s3;
    logic                    r_zero_s3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum      <= '0;
            r_shift_s3 <= '0;
            r_abs_s3   <= 1'b0;
            r_zero_s3  <= 1'b0;
        end else begin
            r_sum      <= w_sum;
            r_shift_s3 <= r_shift_s2;
            r_abs_s3   <= r_abs_s2;
            r_zero_s3  <= r_zero_s2;
        end
    end

    // ---------------- stage 4: shift / abs / clamp ----------------
    logic signed [ACC_W-1:0] w_shifted;
    logic signed [ACC_W-1:0] w_mag;
    logic [CH_W-1:0]         w_clamp;

    always_comb begin
        w_shifted = r_sum >>> r_shift_s3;
        w_mag     = (r_abs_s3 && w_shifted[ACC_W-1]) ? -w_shifted : w_shifted;
        if (w_mag[ACC_W-1]) begin
            w_clamp = '0;
        end else if (w_mag > CH_MAX) begin
            w_clamp = '1;
        end else begin
            w_clamp = w_mag[CH_W-1:0];
        end
    end

    logic [CH_W-1:0] r_ch;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ch <= '0;
        end else begin
            r_ch <= r_zero_s3 ? '0 : w_clamp;
        end
    end

    assign o_ch = r_ch;

endmodule

// File: rtl/convolution_3x3.sv
// -----------------------------------------------------------------------------
// convolution_3x3
// Builds a 3x3 RGB565 window from three vertically aligned rows and applies a
// frame-selectable kernel per channel. Fixed 4-cycle latency, no stall.
// Ports:
//   clk_in, rst_n_in   : clock, asynchronous active-low reset
//   kernel_select_in   : requested kernel, latched at frame start (0,0)
//   row_data_in[3]     : RGB565 pixels at hcount_in; [0]=top, [1]=centre, [2]=bottom
//   hcount_in/vcount_in/data_valid_in : input position and qualifier
//   pixel_out/hcount_out/vcount_out/data_valid_out : filtered stream, window centre
//   kernel_active_out  : kernel applied to the current frame
// -----------------------------------------------------------------------------
module convolution_3x3
    import conv_pkg::*;
#(
    parameter int HRES = 1280,
    parameter int VRES = 720
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [2:0]            kernel_select_in,
    input  logic [2:0][PIX_W-1:0] row_data_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic                  data_valid_in,
    output logic [PIX_W-1:0]      pixel_out,
    output logic [10:0]           hcount_out,
    output logic [9:0]            vcount_out,
    output logic                  data_valid_out,
    output logic [2:0]            kernel_active_out
);

    localparam int PIPE_N = CONV_LATENCY - 1;  // stages after the window register

    // ---------------- kernel latch at frame start ----------------
    logic [2:0] r_kernel_active;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_kernel_active <= '0;
        end else if (data_valid_in && hcount_in == '0 && vcount_in == '0) begin
            r_kernel_active <= kernel_select_in;
        end
    end

    // ---------------- stage 1: window + request ----------------
    // Column 0 holds hcount_in-2, column 2 the newest sample; the centre column
    // therefore sits at hcount_in-1. hcount_in==0 still shifts so the previous
    // line's columns are pushed out before the first output of a new line.
    logic w_req;
    logic w_border;

    assign w_req    = data_valid_in && (hcount_in != '0) && (hcount_in < 11'(HRES));
    assign w_border = (hcount_in == 11'd1) || (vcount_in == '0) ||
                      (vcount_in == 10'(VRES - 1));

    logic [2:0][2:0][PIX_W-1:0] r_win;
    kernel_t                    r_kernel_s1;
    logic                       r_zero_s1;
    logic                       r_valid_s1;
    logic [10:0]                r_hcount_s1;
    logic [9:0]                 r_vcount_s1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_win       <= '0;
            r_kernel_s1 <= '0;
            r_zero_s1   <= 1'b0;
            r_valid_s1  <= 1'b0;
            r_hcount_s1 <= '0;
            r_vcount_s1 <= '0;
        end else begin
            r_valid_s1 <= w_req;
            if (data_valid_in) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                    r_win[r][2] <= row_data_in[r];
                end
                // Kernel travels with the pixel so a frame never mixes kernels.
                r_kernel_s1 <= kernel_lookup(kernel_e'(r_kernel_active));
                r_zero_s1   <= w_border;
                r_hcount_s1 <= hcount_in - 11'd1;
                r_vcount_s1 <= vcount_in;
            end
        end
    end

    // ---------------- stages 2-4: per-channel datapath ----------------
    logic [PIX_W-1:0] w_pixel;

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        localparam int CH_W   = (gi == 0) ? R_W : (gi == 1) ? G_W : B_W;
        localparam int CH_LSB = (gi == 0) ? (G_W + B_W) : (gi == 1) ? B_W : 0;

        logic [2:0][2:0][CH_W-1:0] w_ch_win;
        logic [CH_W-1:0]           w_ch_out;

        always_comb begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    w_ch_win[r][c] = r_win[r][c][CH_LSB +: CH_W];
                end
            end
        end

        conv_channel #(
            .CH_W (CH_W)
        ) u_chan (
            .i_clk    (clk_in),
            .i_rst_n  (rst_n_in),
            .i_win    (w_ch_win),
            .i_kernel (r_kernel_s1),
            .i_zero   (r_zero_s1),
            .o_ch     (w_ch_out)
        );

        assign w_pixel[CH_LSB +: CH_W] = w_ch_out;
    end

    // ---------------- position/valid delay matching stages 2-4 ----------------
    logic [PIPE_N-1:0]       r_valid_pipe;
    logic [PIPE_N-1:0][10:0] r_hcount_pipe;
    logic [PIPE_N-1:0][9:0]  r_vcount_pipe;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid_pipe  <= '0;
            r_hcount_pipe <= '0;
            r_vcount_pipe <= '0;
        end else begin
            r_valid_pipe  <= {r_valid_pipe[PIPE_N-2:0], r_valid_s1};
            r_hcount_pipe <= {r_hcount_pipe[PIPE_N-2:0], r_hcount_s1};
            r_vcount_pipe <= {r_vcount_pipe[PIPE_N-2:0], r_vcount_s1};
        end
    end

    assign pixel_out         = w_pixel;
    assign hcount_out        = r_hcount_pipe[PIPE_N-1];
    assign vcount_out        = r_vcount_pipe[PIPE_N-1];
    assign data_valid_out    = r_valid_pipe[PIPE_N-1];
    assign kernel_active_out = r_kernel_active;

endmodule

// File: tb/tb_convolution_3x3.sv
// -----------------------------------------------------------------------------
// tb_convolution_3x3
// Directed stimulus for convolution_3x3: whole lines of flat, row-striped and
// ramp patterns, each with a hand-derived interior result. Every expected
// output (pixel, position, issue cycle) is queued when its input is driven and
// compared when data_valid_out appears.
// -----------------------------------------------------------------------------
module tb_convolution_3x3;

    localparam int HRES = 1280;
    localparam int VRES = 720;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic [2:0]       kernel_select_in;
    logic [2:0][15:0] row_data_in;
    logic [10:0]      hcount_in;
    logic [9:0]       vcount_in;
    logic             data_valid_in;
    logic [15:0]      pixel_out;
    logic [10:0]      hcount_out;
    logic [9:0]       vcount_out;
    logic             data_valid_out;
    logic [2:0]       kernel_active_out;

    convolution_3x3 #(
        .HRES (HRES),
        .VRES (VRES)
    ) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .kernel_select_in  (kernel_select_in),
        .row_data_in       (row_data_in),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .data_valid_in     (data_valid_in),
        .pixel_out         (pixel_out),
        .hcount_out        (hcount_out),
        .vcount_out        (vcount_out),
        .data_valid_out    (data_valid_out),
        .kernel_active_out (kernel_active_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] pix;
        int          h;
        int          v;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;

    always @(posedge clk_in) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_in) begin
        if (data_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(hcount_out), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("pixel",   32'(pixel_out),  32'(mon_e.pix));
                check("hcount",  32'(hcount_out), 32'(mon_e.h));
                check("vcount",  32'(vcount_out), 32'(mon_e.v));
                check("latency", 32'(cycle - mon_e.cyc), 32'd4);
            end
        end
    end

    // mode 0: rows r0/r1/r2 held constant, interior result exp_int.
    // mode 1: R ramp (R = column mod 32) on all rows, sobel_x result.
    task automatic drive_line(input int v, input logic [15:0] r0, input logic [15:0] r1,
                              input logic [15:0] r2, input int mode,
                              input logic [15:0] exp_int, input int gap, input int npix);
        exp_t        e;
        logic [15:0] px;
        int          c;
        for (int h = 0; h < npix; h++) begin
            hcount_in     = 11'(h);
            vcount_in     = 10'(v);
            data_valid_in = 1'b1;
            if (mode == 1) begin
                px = 16'((h % 32) << 11);
                row_data_in[0] = px;
                row_data_in[1] = px;
                row_data_in[2] = px;
            end else begin
                row_data_in[0] = r0;
                row_data_in[1] = r1;
                row_data_in[2] = r2;
            end
            if (h >= 1) begin
                c = h - 1;
                if (c == 0 || v == 0 || v == VRES - 1) begin
                    e.pix = 16'h0000;
                end else if (mode == 1) begin
                    e.pix = ((c % 32) == 31 || (c % 32) == 0) ? 16'hF800 : 16'h4000;
                end else begin
                    e.pix = exp_int;
                end
                e.h   = c;
                e.v   = v;
                e.cyc = cycle;
                exp_q.push_back(e);
            end
            @(posedge clk_in);
            #1;
            if (gap > 0) begin
                data_valid_in = 1'b0;
                repeat (gap) @(posedge clk_in);
                #1;
            end
        end
        data_valid_in = 1'b0;
        $display("[TB] line v=%0d sel=%0d active=%0d pixels=%0d gap=%0d",
                 v, kernel_select_in, kernel_active_out, npix, gap);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_in);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Frame start: a (0,0) valid latches kernel_select_in, visible one cycle later;
    // the rest of line 0 is border and must come out as zeros.
    task automatic frame_start(input logic [2:0] sel);
        kernel_select_in = sel;
        drive_line(0, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0, 16'hA5A5, 0, 1);
        check("kernel_latch", 32'(kernel_active_out), 32'(sel));
        drive_line(0, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0, 16'hA5A5, 0, HRES);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in         = 1'b0;
        kernel_select_in = 3'd0;
        row_data_in      = '0;
        hcount_in        = '0;
        vcount_in        = '0;
        data_valid_in    = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid",  32'(data_valid_out),    32'd0);
        check("rst_pixel",  32'(pixel_out),         32'd0);
        check("rst_hcount", 32'(hcount_out),        32'd0);
        check("rst_vcount", 32'(vcount_out),        32'd0);
        check("rst_kernel", 32'(kernel_active_out), 32'd0);
        rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;

        // Identity, border lines
        frame_start(3'd0);
        drive_line(5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0, 16'hA5A5, 0, HRES);
        drain();
        drive_line(VRES - 1, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0, 16'hA5A5, 0, HRES);
        drain();

        // Mid-frame select change: identity stays in force
        kernel_select_in = 3'd1;
        drive_line(100, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'hFFFF, 0, HRES);
        drain();
        check("kernel_hold", 32'(kernel_active_out), 32'd0);

        // Gaussian
        frame_start(3'd1);
        drive_line(50, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h7BEF, 0, HRES);
        drain();
        drive_line(51, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 16'hFFFF, 0, HRES);
        drain();

        // Sharpen
        frame_start(3'd2);
        drive_line(10, 16'h0841, 16'h0841, 16'h0841, 0, 16'h0841, 0, HRES);
        drain();

        // Sobel_x on a ramp, continuous then with valid every 3rd cycle
        frame_start(3'd3);
        drive_line(20, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 0, HRES);
        drain();
        drive_line(21, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 2, HRES);
        drain();

        // Sobel_y: top row only, negative sum folded by abs
        frame_start(3'd4);
        drive_line(30, 16'h0841, 16'h0000, 16'h0000, 0, 16'h2104, 0, HRES);
        drain();

        // Unused encoding falls back to identity
        frame_start(3'd5);
        drive_line(31, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'hFFFF, 0, HRES);
        drain();

        // Asynchronous reset mid-line
        kernel_select_in = 3'd3;
        drive_line(40, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0, 16'hA5A5, 0, 20);
        #2;
        check("pre_rst_valid", 32'(data_valid_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        check("async_rst_valid",  32'(data_valid_out),    32'd0);
        check("async_rst_pixel",  32'(pixel_out),         32'd0);
        check("async_rst_kernel", 32'(kernel_active_out), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        drive_line(5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0, 16'hA5A5, 0, HRES);
        drain();
        check("post_rst_kernel", 32'(kernel_active_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
